// File: rtl/hc4e_prog_loader.sv
// rtl/hc4e_prog_loader.sv - UART program loader and 256x8 instruction memory for the HC4e core
// Optional inter-byte load timeout: HC4E_LOADER_TIMEOUT_EN
module hc4e_prog_loader #(
    parameter int CLK_HZ         = 20_000_000,
    parameter int BAUD           = 115200,
    parameter int TIMEOUT_CYCLES = 20_000_000
) (
    input  logic       clock,
    input  logic       nReset,
    input  logic       uart_rx,
    input  logic [7:0] pc_in,
    output logic [7:0] instruction,
    output logic       cpu_nReset,
    output logic       loading,
    output logic       load_err,
    output logic [8:0] byte_count
);
    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = $clog2(DIV + 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {S_SYNC, S_LEN, S_DATA, S_SUM, S_RUN, S_ERR} state_t;

    rx_state_t     rx_state_q, rx_state_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          rx_valid_q, rx_valid_d, rx_ferr_q, rx_ferr_d;

    state_t     state_q, state_d;
    logic [8:0] len_q, len_d, bc_q, bc_d;
    logic [7:0] sum_q, sum_d;
    logic       err_q, err_d, cpu_q, cpu_d, mem_we;
    logic [7:0] mem_q [256];

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_valid_q <= 1'b0;
            rx_ferr_q  <= 1'b0;
        end else begin
            rx_meta_q  <= uart_rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_valid_q <= rx_valid_d;
            rx_ferr_q  <= rx_ferr_d;
        end
    end

    // Start edge is re-checked at mid start bit; all later samples land mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_valid_d = 1'b0;
        rx_ferr_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: if (rx_cnt_q == HALF_M1) begin
                rx_cnt_d   = '0;
                rx_bit_d   = '0;
                rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = '0;
                rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                rx_bit_d   = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == DIV_M1) begin
                rx_cnt_d   = '0;
                rx_valid_d = rx_sync_q;
                rx_ferr_d  = !rx_sync_q;
                rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign loading = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_SUM);

`ifdef HC4E_LOADER_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        to_hit;
    assign to_hit = loading && !rx_valid_q && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) to_cnt_q <= '0;
        else         to_cnt_q <= (loading && !rx_valid_q) ? to_cnt_q + 32'd1 : '0;
    end
`else
    logic to_hit;
    assign to_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bc_d    = bc_q;
        sum_d   = sum_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        if (rx_ferr_q || to_hit) begin
            state_d = S_ERR;
            err_d   = 1'b1;
        end else if (rx_valid_q) begin
            case (state_q)
                S_SYNC, S_ERR, S_RUN: if (rx_shift_q == 8'h55) begin
                    state_d = S_LEN;
                    err_d   = 1'b0;
                end
                S_LEN: begin
                    len_d   = (rx_shift_q == 8'h00) ? 9'd256 : {1'b0, rx_shift_q};
                    bc_d    = '0;
                    sum_d   = '0;
                    state_d = S_DATA;
                end
                S_DATA: begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + rx_shift_q;
                    bc_d   = bc_q + 9'd1;
                    if (bc_q + 9'd1 == len_q) state_d = S_SUM;
                end
                S_SUM: begin
                    if (rx_shift_q == sum_q) begin
                        state_d = S_RUN;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
                default: state_d = S_SYNC;
            endcase
        end
        cpu_d = (state_d == S_RUN);
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_SYNC;
            len_q   <= '0;
            bc_q    <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            cpu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bc_q    <= bc_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            cpu_q   <= cpu_d;
        end
    end

    // Image survives nReset, so the array has no reset.
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[bc_q[7:0]] <= rx_shift_q;
    end

    assign instruction = (state_q == S_RUN) ? mem_q[pc_in] : 8'hE1;
    assign cpu_nReset  = cpu_q;
    assign load_err    = err_q;
    assign byte_count  = bc_q;
endmodule

// File: tb/tb_hc4e_prog_loader.sv
// tb/tb_hc4e_prog_loader.sv - directed bench for hc4e_prog_loader
module tb_hc4e_prog_loader;
    localparam int DIV = 10;

    logic       clock = 1'b0;
    logic       nReset = 1'b0;
    logic       uart_rx = 1'b1;
    logic [7:0] pc_in = 8'h00;
    logic [7:0] instruction;
    logic       cpu_nReset, loading, load_err;
    logic [8:0] byte_count;
    int         n_vec = 0;
    int         n_err = 0;

    hc4e_prog_loader #(.CLK_HZ(1000), .BAUD(100), .TIMEOUT_CYCLES(1000)) dut (
        .clock(clock), .nReset(nReset), .uart_rx(uart_rx), .pc_in(pc_in),
        .instruction(instruction), .cpu_nReset(cpu_nReset), .loading(loading),
        .load_err(load_err), .byte_count(byte_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Start, data bits and the first half of the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clock);
        uart_rx = 1'b0;
        wait_neg(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_neg(DIV);
        end
        uart_rx = stop;
        wait_neg(DIV / 2);
    endtask

    task automatic finish_frame();
        wait_neg(DIV - DIV / 2);
        uart_rx = 1'b1;
        wait_neg(2 * DIV);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b1);
        finish_frame();
    endtask

    task automatic instr_at(input string tag, input logic [7:0] pc, input logic [7:0] exp);
        pc_in = pc;
        #1;
        check(tag, {1'b0, instruction}, {1'b0, exp});
    endtask

    initial begin
        wait_neg(4);
        check("rst_cpu", {8'h0, cpu_nReset}, 9'h0);
        check("rst_loading", {8'h0, loading}, 9'h0);
        check("rst_err", {8'h0, load_err}, 9'h0);
        check("rst_count", byte_count, 9'h0);
        instr_at("rst_instr", 8'h00, 8'hE1);
        nReset = 1'b1;
        wait_neg(3);

        // Sum of A1 B2 E0 is 0x33, so 0x34 is rejected.
        send_byte(8'h55); send_byte(8'h03);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hE0); send_byte(8'h34);
        check("sum34_err", {8'h0, load_err}, 9'h1);
        check("sum34_cpu", {8'h0, cpu_nReset}, 9'h0);

        send_byte(8'h55);
        check("sync_clr_err", {8'h0, load_err}, 9'h0);
        send_byte(8'h03);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hE0);
        send_frame(8'h33, 1'b1);
        check("nom_cpu_mid_stop", {8'h0, cpu_nReset}, 9'h0);
        finish_frame();
        check("nom_cpu_run", {8'h0, cpu_nReset}, 9'h1);
        check("nom_count", byte_count, 9'd3);
        check("nom_err", {8'h0, load_err}, 9'h0);
        check("nom_loading", {8'h0, loading}, 9'h0);
        instr_at("nom_pc1", 8'h01, 8'hB2);
        instr_at("nom_pc0", 8'h00, 8'hA1);
        instr_at("nom_pc2", 8'h02, 8'hE0);

        send_byte(8'h55);
        check("reload_cpu", {8'h0, cpu_nReset}, 9'h0);
        check("reload_loading", {8'h0, loading}, 9'h1);
        instr_at("reload_instr", 8'h01, 8'hE1);
        send_byte(8'h01); send_byte(8'hC5); send_byte(8'hC5);
        check("reload_run", {8'h0, cpu_nReset}, 9'h1);
        check("reload_count", byte_count, 9'd1);
        instr_at("reload_pc0", 8'h00, 8'hC5);
        instr_at("reload_pc1", 8'h01, 8'hB2);
        instr_at("reload_pc2", 8'h02, 8'hE0);

        send_byte(8'h55); send_byte(8'h02);
        send_byte(8'h10); send_byte(8'h20); send_byte(8'h31);
        check("bad_err", {8'h0, load_err}, 9'h1);
        check("bad_cpu", {8'h0, cpu_nReset}, 9'h0);
        check("bad_loading", {8'h0, loading}, 9'h0);
        instr_at("bad_pc0", 8'h00, 8'hE1);
        instr_at("bad_pc1", 8'h01, 8'hE1);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hAA);
        check("recover_cpu", {8'h0, cpu_nReset}, 9'h1);
        check("recover_err", {8'h0, load_err}, 9'h0);
        instr_at("recover_pc0", 8'h00, 8'hAA);
        instr_at("recover_pc1", 8'h01, 8'h20);

        send_byte(8'h55); send_byte(8'h02);
        @(negedge clock); uart_rx = 1'b0;
        @(negedge clock); uart_rx = 1'b1;
        wait_neg(12 * DIV);
        check("glitch_count", byte_count, 9'd0);
        check("glitch_loading", {8'h0, loading}, 9'h1);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("glitch_run", {8'h0, cpu_nReset}, 9'h1);
        check("glitch_len", byte_count, 9'd2);
        instr_at("glitch_pc1", 8'h01, 8'h22);

        send_byte(8'h55); send_byte(8'h02); send_byte(8'h10);
        send_frame(8'h20, 1'b0);
        finish_frame();
        check("frame_err", {8'h0, load_err}, 9'h1);
        check("frame_cpu", {8'h0, cpu_nReset}, 9'h0);
        check("frame_loading", {8'h0, loading}, 9'h0);
        check("frame_count", byte_count, 9'd1);

        send_byte(8'h55); send_byte(8'h03); send_byte(8'h77);
        check("midload_count", byte_count, 9'd1);
        @(negedge clock); nReset = 1'b0;
        #1;
        check("arst_cpu", {8'h0, cpu_nReset}, 9'h0);
        check("arst_count", byte_count, 9'd0);
        check("arst_loading", {8'h0, loading}, 9'h0);
        check("arst_err", {8'h0, load_err}, 9'h0);
        wait_neg(2); nReset = 1'b1; wait_neg(2);
        send_byte(8'h88);
        check("arst_sync_wait", {8'h0, loading}, 9'h0);
        send_byte(8'h55); send_byte(8'h01); send_byte(8'h99); send_byte(8'h99);
        check("arst_run", {8'h0, cpu_nReset}, 9'h1);
        instr_at("arst_pc0", 8'h00, 8'h99);
        instr_at("arst_pc1", 8'h01, 8'h22);

        send_byte(8'h55); send_byte(8'h00);
        for (int a = 0; a < 256; a++) send_byte(8'(a));
        check("full_loading", {8'h0, loading}, 9'h1);
        send_byte(8'h80);
        check("full_run", {8'h0, cpu_nReset}, 9'h1);
        check("full_count", byte_count, 9'd256);
        instr_at("full_pcff", 8'hFF, 8'hFF);
        instr_at("full_pc80", 8'h80, 8'h80);
        instr_at("full_pc00", 8'h00, 8'h00);

`ifdef HC4E_LOADER_TIMEOUT_EN
        send_byte(8'h55); send_byte(8'h05);
        wait_neg(900);
        check("to_still_loading", {8'h0, loading}, 9'h1);
        wait_neg(200);
        check("to_loading", {8'h0, loading}, 9'h0);
        check("to_err", {8'h0, load_err}, 9'h1);
        check("to_cpu", {8'h0, cpu_nReset}, 9'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
